// File: rtl/reg_cmd_sequencer.sv
// Command sequencer between the UART frame decoder and the register block.
// Handles single write, single read with readback, and a paced full-bank dump.
module reg_cmd_sequencer #(
    parameter int WORD_WIDTH   = 8,
    parameter int VALUE_WORDS  = 4,
    parameter int REG_DEPTH    = 16,
    parameter int TX_GAP       = 8,
    parameter int READ_TIMEOUT = 64,
    parameter logic [WORD_WIDTH-1:0] CMD_WRITE = 8'h01,
    parameter logic [WORD_WIDTH-1:0] CMD_READ  = 8'h02,
    parameter logic [WORD_WIDTH-1:0] CMD_DUMP  = 8'h03
) (
    input  logic                              clk,
    input  logic                              i_reset,
    input  logic [WORD_WIDTH-1:0]             i_cmd,
    input  logic [WORD_WIDTH-1:0]             i_addr,
    input  logic [WORD_WIDTH*VALUE_WORDS-1:0] i_value,
    input  logic                              i_dv,
    output logic                              o_w_en,
    output logic [WORD_WIDTH-1:0]             o_w_addr,
    output logic [WORD_WIDTH*VALUE_WORDS-1:0] o_w_value,
    output logic                              o_r_en,
    output logic [WORD_WIDTH-1:0]             o_r_addr,
    input  logic [WORD_WIDTH*VALUE_WORDS-1:0] i_r_value,
    input  logic                              i_r_valid,
    input  logic                              i_tx_afull,
    output logic [WORD_WIDTH*VALUE_WORDS-1:0] o_tx_data,
    output logic                              o_tx_dv,
    output logic                              o_busy,
    output logic                              o_err,
    output logic [1:0]                        o_err_code,
    output logic                              o_drop,
    output logic [2:0]                        o_state
);

    localparam int GW = $clog2(TX_GAP + 1);
    localparam int TW = $clog2(READ_TIMEOUT + 1);
    localparam logic [WORD_WIDTH-1:0] LAST    = WORD_WIDTH'(REG_DEPTH - 1);
    localparam logic [GW-1:0]         GAP_MAX = GW'(TX_GAP);
    localparam logic [TW-1:0]         TO_LAST = TW'(READ_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_TX_WAIT = 3'd4,
        S_TX      = 3'd5,
        S_GAP     = 3'd6
    } state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] addr;
    logic                  dump;
    logic [GW-1:0]         gap;
    logic [TW-1:0]         tcnt;
    logic                  in_range;

    assign in_range = (i_addr <= LAST);
    assign o_state  = state;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            dump       <= 1'b0;
            gap        <= GAP_MAX;
            tcnt       <= '0;
            o_w_en     <= 1'b0;
            o_w_addr   <= '0;
            o_w_value  <= '0;
            o_r_en     <= 1'b0;
            o_r_addr   <= '0;
            o_tx_data  <= '0;
            o_tx_dv    <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= 2'd0;
            o_drop     <= 1'b0;
        end else begin
            o_w_en  <= 1'b0;
            o_r_en  <= 1'b0;
            o_tx_dv <= 1'b0;
            o_err   <= 1'b0;
            o_drop  <= 1'b0;
            if (gap != GAP_MAX) gap <= gap + 1'b1;
            if (i_dv && state != S_IDLE) o_drop <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (i_dv) begin
                        if (i_cmd == CMD_WRITE && in_range) begin
                            o_w_en    <= 1'b1;
                            o_w_addr  <= i_addr;
                            o_w_value <= i_value;
                            o_busy    <= 1'b1;
                            state     <= S_WRITE;
                        end else if (i_cmd == CMD_READ && in_range) begin
                            addr     <= i_addr;
                            o_r_en   <= 1'b1;
                            o_r_addr <= i_addr;
                            o_busy   <= 1'b1;
                            state    <= S_RD_REQ;
                        end else if (i_cmd == CMD_DUMP) begin
                            addr     <= '0;
                            dump     <= 1'b1;
                            o_r_en   <= 1'b1;
                            o_r_addr <= '0;
                            o_busy   <= 1'b1;
                            state    <= S_RD_REQ;
                        end else if (i_cmd == CMD_WRITE || i_cmd == CMD_READ) begin
                            o_err      <= 1'b1;
                            o_err_code <= 2'd2;
                        end else begin
                            o_err      <= 1'b1;
                            o_err_code <= 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                S_RD_REQ: begin
                    // The request cycle itself counts toward the timeout.
                    tcnt  <= TW'(1);
                    state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (i_r_valid) begin
                        o_tx_data <= i_r_value;
                        state     <= S_TX_WAIT;
                    end else if (tcnt == TO_LAST) begin
                        o_err      <= 1'b1;
                        o_err_code <= 2'd3;
                        dump       <= 1'b0;
                        o_busy     <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_TX_WAIT: begin
                    if (!i_tx_afull && gap == GAP_MAX) begin
                        o_tx_dv <= 1'b1;
                        gap     <= '0;
                        state   <= S_TX;
                    end
                end
                S_TX: begin
                    state <= S_GAP;
                end
                S_GAP: begin
                    if (dump && addr != LAST) begin
                        addr     <= addr + 1'b1;
                        o_r_en   <= 1'b1;
                        o_r_addr <= addr + 1'b1;
                        state    <= S_RD_REQ;
                    end else begin
                        dump   <= 1'b0;
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_cmd_sequencer.md
Name: reg_cmd_sequencer

Overview:
Sequences register-block accesses from decoded UART command frames: single write, single read with readback, and a full-bank dump. Sits between the frame deserializer (after its dv pulse) and the register_block / serializer / fifo_uart chain. Owns the register_block read and write ports and paces read responses into the serializer so the TX FIFO never overflows.

Parameters:
WORD_WIDTH, 8, bits per UART word; also the width of the cmd and addr fields.
VALUE_WORDS, 4, words per register value; register width is WORD_WIDTH*VALUE_WORDS.
REG_DEPTH, 16, number of registers; valid addresses are 0..REG_DEPTH-1.
TX_GAP, 8, minimum clocks between o_tx_dv pulses; must be at least VALUE_WORDS+1 so the serializer drains.
READ_TIMEOUT, 64, clocks allowed for i_r_valid after o_r_en.
CMD_WRITE, 8'h01, write opcode.
CMD_READ, 8'h02, read opcode.
CMD_DUMP, 8'h03, dump opcode.

Ports:
clk  in  1  clock.
i_reset  in  1  reset; synchronous, active-high.
i_cmd  in  WORD_WIDTH  opcode of the frame.
i_addr  in  WORD_WIDTH  register address.
i_value  in  WORD_WIDTH*VALUE_WORDS  write value.
i_dv  in  1  frame valid; single-cycle pulse.
o_w_en  out  1  register write strobe.
o_w_addr  out  WORD_WIDTH  write address.
o_w_value  out  WORD_WIDTH*VALUE_WORDS  write value.
o_r_en  out  1  register read strobe.
o_r_addr  out  WORD_WIDTH  read address.
i_r_value  in  WORD_WIDTH*VALUE_WORDS  read data.
i_r_valid  in  1  read data valid.
i_tx_afull  in  1  TX FIFO almost full.
o_tx_data  out  WORD_WIDTH*VALUE_WORDS  response value to the serializer.
o_tx_dv  out  1  response strobe to the serializer.
o_busy  out  1  high whenever the state is not IDLE.
o_err  out  1  error pulse.
o_err_code  out  2  error code: 1 = unknown opcode, 2 = address out of range, 3 = read timeout, 0 = none.
o_drop  out  1  pulse when a frame arrives while busy.
o_state  out  3  encoded state, for debug.

Behaviour:
- Reset (synchronous, i_reset high at a clk edge):
  - All strobes, o_busy, o_err, o_drop, o_err_code, o_w_* , o_r_addr and o_tx_data go to 0.
  - State goes to IDLE.
  - Reset wins over every other event and aborts any operation in progress, including a dump; no strobe is issued in the same cycle.
- All outputs are registered. All strobes (w_en, r_en, tx_dv, err, drop) are exactly one cycle wide.
- States and encodings: IDLE=0, WRITE=1, RD_REQ=2, RD_WAIT=3, TX_WAIT=4, TX=5, GAP=6.
- IDLE, on i_dv:
  - i_addr >= REG_DEPTH with WRITE or READ: pulse o_err with code 2 on the next cycle, stay in IDLE.
  - Any opcode other than WRITE, READ or DUMP: pulse o_err with code 1, stay in IDLE.
  - WRITE: go to WRITE.
  - READ: latch addr, go to RD_REQ.
  - DUMP: set the internal address to 0, set the dump flag, go to RD_REQ.
- WRITE: o_w_en=1 with o_w_addr/o_w_value latched from the frame; next state IDLE. o_w_en asserts 1 cycle after i_dv.
- RD_REQ:
  - o_r_en=1 with o_r_addr = current address; clear the timeout counter; go to RD_WAIT.
  - For READ, o_r_en asserts 1 cycle after i_dv.
- RD_WAIT:
  - On i_r_valid, latch i_r_value into o_tx_data and go to TX_WAIT.
  - If the timeout counter reaches READ_TIMEOUT first: o_err code 3, clear the dump flag, go to IDLE.
  - i_r_valid in the same cycle as the timeout counter reaching READ_TIMEOUT counts as valid.
- TX_WAIT: remain while i_tx_afull=1 or the gap counter < TX_GAP; otherwise go to TX.
  - The gap counter counts from the last o_tx_dv and saturates at TX_GAP.
  - After reset it starts saturated, so the first response has no gap delay.
- TX: o_tx_dv=1, restart the gap counter, go to GAP.
- GAP:
  - If dump and address == REG_DEPTH-1: clear the dump flag, go to IDLE.
  - If dump otherwise: address+1, go to RD_REQ.
  - Else go to IDLE.
  - The address increment is WORD_WIDTH wide; the last-address check prevents wrap-around.
- Frames while busy:
  - i_dv in any non-IDLE state is discarded: o_drop pulses the next cycle and the state is unaffected.
  - i_dv in the same cycle the state returns to IDLE is also dropped; the frame is accepted only when the state is IDLE at that edge.
- o_err_code holds the last error until the next error or reset.
- i_r_valid outside RD_WAIT is ignored.
- Best-case READ latency, i_dv to o_tx_dv: 1 (r_en) + register latency + 2 clocks.

Test Plan:
- Reset, then WRITE addr=3 value=32'hDEADBEEF -> o_w_en one cycle, 1 clk after i_dv, with addr 3 and value DEADBEEF; o_tx_dv stays 0.
- READ addr=3 after that write -> o_r_en addr 3; o_tx_dv pulses once with o_tx_data=32'hDEADBEEF.
- DUMP with register n preloaded to n*32'h01010101 -> exactly 16 o_tx_dv pulses with values in address order 0..15; pulses at least TX_GAP clocks apart; o_busy drops after the 16th.
- DUMP while i_tx_afull is held high for 100 clks after the 2nd response -> no o_tx_dv during the hold; dump resumes after release; 16 pulses total, none lost.
- READ addr=16 -> o_err with code 2 and no r_en. Opcode 8'h7F -> o_err with code 1. Read with i_r_valid never asserted -> o_err with code 3, 64 clks after o_r_en, then IDLE.
- i_dv during a dump -> o_drop pulse and the dump completes unaffected. i_reset mid-dump at address 5 -> next clk all outputs 0, IDLE, and no further o_tx_dv.
